// File: rtl/taxi_axis_if.sv
`default_nettype none
// ============================================================================
// Module   : taxi_axis_if
// Purpose  : Minimal AXI4-Stream bundle carrying tdata/tvalid/tready.
// Ports    : master modport drives tdata/tvalid and receives tready;
//            slave modport receives tdata/tvalid and drives tready.
// Revision : 1.0 - initial release
// ============================================================================
interface taxi_axis_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/taxi_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : taxi_uart_tx_cfg
// Purpose  : UART transmitter with an AXI4-Stream input, internal TX FIFO and
//            run-time frame format (5-9 data bits, parity, 1/2 stop bits).
//            Bit time is max(prescale,1)*8 clk cycles. Frames are sent
//            back-to-back while the FIFO holds data.
// Ports    : clk, rst_n (async assert, active low)
//            s_axis_tx     - stream sink (tdata/tvalid/tready)
//            txd           - serial output, idle high
//            busy          - frame or break in progress
//            fifo_count    - number of FIFO entries
//            cfg_data_bits - data bits, clamped to [5, min(9,DATA_W)]
//            cfg_parity    - 0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//            cfg_stop_bits - 0 one stop bit, 1 two stop bits
//            prescale      - bit time = max(prescale,1)*8 clk
//            break_req     - line break request (TAXI_UART_TX_BREAK_EN only)
// Options  : define TAXI_UART_TX_BREAK_EN to add the break_req port and the
//            break / mark-after-break states.
// Revision : 1.0 - initial release
// ============================================================================
module taxi_uart_tx_cfg #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  taxi_axis_if.slave                  s_axis_tx,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  input  logic [3:0]                  cfg_data_bits,
  input  logic [2:0]                  cfg_parity,
  input  logic                        cfg_stop_bits,
`ifdef TAXI_UART_TX_BREAK_EN
  input  logic                        break_req,
`endif
  input  logic [15:0]                 prescale
);

  localparam int DATA_W = $bits(s_axis_tx.tdata);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int MAXB   = (DATA_W < 9) ? DATA_W : 9;
  localparam logic [3:0]    C_MAXB = 4'(MAXB);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
`ifdef TAXI_UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd6,
    ST_MAB    = 3'd7
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        nbits_q, nbits_d;
  logic [3:0]        bitno_q, bitno_d;
  logic [2:0]        pmode_q, pmode_d;
  logic              stop2_q, stop2_d;
  logic [15:0]       presc_q, presc_d;
  logic [18:0]       cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              tready_q, tready_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              w_push, w_pop, w_load, w_frame_end, w_bit_end, w_nonempty;
  logic [15:0]       w_presc_in;
  logic [3:0]        w_nbits;
  logic [18:0]       w_reload;

  assign w_push     = s_axis_tx.tvalid & tready_q;
  assign w_nonempty = (count_q != '0);
  assign w_bit_end  = (cnt_q == '0);
  assign w_presc_in = (prescale == 16'd0) ? 16'd1 : prescale;
  // Reload value for the bit currently in progress uses the latched prescale.
  assign w_reload   = {presc_q, 3'b000} - 19'd1;

  always_comb begin
    if (cfg_data_bits < 4'd5)        w_nbits = 4'd5;
    else if (cfg_data_bits > C_MAXB) w_nbits = C_MAXB;
    else                             w_nbits = cfg_data_bits;
  end

  // FIFO storage carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= s_axis_tx.tdata;
  end

  always_comb begin
    state_d     = state_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    shreg_d     = shreg_q;
    nbits_d     = nbits_q;
    bitno_d     = bitno_q;
    pmode_d     = pmode_q;
    stop2_d     = stop2_q;
    presc_d     = presc_q;
    par_d       = par_q;
    cnt_d       = w_bit_end ? w_reload : cnt_q - 19'd1;
    w_load      = 1'b0;
    w_frame_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
`ifdef TAXI_UART_TX_BREAK_EN
        if (break_req) begin
          state_d = ST_BREAK;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end else
`endif
        if (w_nonempty) w_load = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) begin
          state_d = ST_DATA;
          txd_d   = shreg_q[0];
          par_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bitno_d = 4'd1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (bitno_q == nbits_q) begin
            if (pmode_q >= 3'd1 && pmode_q <= 3'd4) begin
              state_d = ST_PARITY;
              case (pmode_q)
                3'd1:    txd_d = par_q;
                3'd2:    txd_d = ~par_q;
                3'd3:    txd_d = 1'b1;
                default: txd_d = 1'b0;
              endcase
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d   = shreg_q[0];
            par_d   = par_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
            bitno_d = bitno_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (stop2_q) state_d = ST_STOP2;
          else         w_frame_end = 1'b1;
        end
      end
      ST_STOP2: begin
        if (w_bit_end) w_frame_end = 1'b1;
      end
`ifdef TAXI_UART_TX_BREAK_EN
      ST_BREAK: begin
        cnt_d = cnt_q;
        if (!break_req) begin
          state_d = ST_MAB;
          txd_d   = 1'b1;
          presc_d = w_presc_in;
          cnt_d   = {w_presc_in, 3'b000} - 19'd1;
        end
      end
      ST_MAB: begin
        if (w_bit_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // End of the last stop bit: chain straight into the next frame so the
    // line never shows an idle gap between queued words.
    if (w_frame_end) begin
`ifdef TAXI_UART_TX_BREAK_EN
      if (break_req) begin
        state_d = ST_BREAK;
        txd_d   = 1'b0;
      end else
`endif
      if (w_nonempty) begin
        w_load = 1'b1;
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end

    // Pop and latch word plus the whole frame format for this frame.
    if (w_load) begin
      state_d = ST_START;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
      shreg_d = mem_q[rd_ptr_q];
      nbits_d = w_nbits;
      pmode_d = cfg_parity;
      stop2_d = cfg_stop_bits;
      presc_d = w_presc_in;
      cnt_d   = {w_presc_in, 3'b000} - 19'd1;
    end
  end

  assign w_pop = w_load;

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    tready_d = (count_d != C_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      shreg_q  <= '0;
      nbits_q  <= 4'd5;
      bitno_q  <= '0;
      pmode_q  <= '0;
      stop2_q  <= 1'b0;
      presc_q  <= 16'd1;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      shreg_q  <= shreg_d;
      nbits_q  <= nbits_d;
      bitno_q  <= bitno_d;
      pmode_q  <= pmode_d;
      stop2_q  <= stop2_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      tready_q <= tready_d;
    end
  end

  assign s_axis_tx.tready = tready_q;
  assign txd              = txd_q;
  assign busy             = busy_q;
  assign fifo_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_taxi_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_taxi_uart_tx_cfg
// Purpose  : Directed self-checking bench for taxi_uart_tx_cfg
//            (FIFO_DEPTH=4, DATA_W=9).
// Revision : 1.0 - initial release
// ============================================================================
module tb_taxi_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        txd, busy;
  logic [2:0]  fifo_count;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [2:0]  cfg_parity = 3'd0;
  logic        cfg_stop_bits = 1'b0;
  logic [15:0] prescale = 16'd1;
`ifdef TAXI_UART_TX_BREAK_EN
  logic        break_req = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  taxi_axis_if #(.DATA_W(9)) axis ();

  taxi_uart_tx_cfg #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tx     (axis),
    .txd           (txd),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop_bits (cfg_stop_bits),
`ifdef TAXI_UART_TX_BREAK_EN
    .break_req     (break_req),
`endif
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8N1 frame as a bit vector, index 0 = start bit.
  function automatic logic [15:0] mk8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // Offer one beat; returns just after the accepting edge.
  task automatic push_one(input logic [8:0] d);
    bit ok = 0;
    axis.tdata  = d;
    axis.tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (axis.tready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    axis.tvalid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  // Called at the negedge of the first start-bit cycle; checks every cycle of
  // every bit and ends on the negedge of the first cycle after the frame.
  task automatic check_frame(input logic [15:0] bits, input int n, input int t, input string tag);
    for (int i = 0; i < n; i++) begin
      int match = 0;
      for (int c = 0; c < t; c++) begin
        if (txd === bits[i] && busy === 1'b1) match++;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, i), match, t);
    end
  endtask

  // Push into an idle, empty transmitter and verify latency, frame and idle.
  task automatic send_and_check(input logic [8:0] d, input logic [15:0] bits,
                                input int n, input int t, input string tag);
    push_one(d);
    @(negedge clk);
    chk({tag, "_count1"}, fifo_count, 1);
    chk({tag, "_pre_txd"}, txd, 1);
    @(negedge clk);
    chk({tag, "_latency_txd"}, txd, 0);
    chk({tag, "_count0"}, fifo_count, 0);
    check_frame(bits, n, t, tag);
    chk({tag, "_idle_txd"}, txd, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  logic [8:0] vals [6];
  int acc, idx, lowcnt, busycnt;
  bit rs;

  initial begin
    axis.tdata  = '0;
    axis.tvalid = 1'b0;

    // Reset values
    #12;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tready", axis.tready, 0);
    chk("rst_count", fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_tready_before_edge", axis.tready, 0);
    @(posedge clk); #1;
    chk("rel_tready_after_edge", axis.tready, 1);
    @(negedge clk);

    // 8N1 prescale=1, 0x55
    send_and_check(9'h055, 16'h02AA, 10, 8, "f8n1");

    // 7E2 prescale=2, 0x03
    @(negedge clk);
    cfg_data_bits = 4'd7; cfg_parity = 3'd1; cfg_stop_bits = 1'b1; prescale = 16'd2;
    send_and_check(9'h003, 16'h0606, 11, 16, "f7e2");

    // 9O1 with cfg_data_bits=12 (clamps to 9), prescale=0 (acts as 1)
    @(negedge clk);
    cfg_data_bits = 4'd12; cfg_parity = 3'd2; cfg_stop_bits = 1'b0; prescale = 16'd0;
    send_and_check(9'h1FF, 16'h0BFE, 12, 8, "f9o1");

    // cfg_data_bits=2 clamps to 5, no parity
    @(negedge clk);
    cfg_data_bits = 4'd2; cfg_parity = 3'd0; prescale = 16'd1;
    send_and_check(9'h015, 16'h006A, 7, 8, "f5n1");

    // FIFO fill with tvalid held, back-to-back frames
    @(negedge clk);
    cfg_data_bits = 4'd8;
    vals[0] = 9'h081; vals[1] = 9'h03C; vals[2] = 9'h0A5;
    vals[3] = 9'h00F; vals[4] = 9'h0FF; vals[5] = 9'h000;
    acc = 0; idx = 0;
    axis.tdata = vals[0];
    axis.tvalid = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      rs = axis.tready;
      @(posedge clk); #1;
      if (rs) begin
        acc++;
        if (idx < 5) idx++;
        axis.tdata = vals[idx];
      end
      @(negedge clk);
      if (j == 2) chk("fifo_first_start", txd, 0);
    end
    axis.tvalid = 1'b0;
    chk("fifo_accepted", acc, 5);
    chk("fifo_tready_full", axis.tready, 0);
    chk("fifo_count4", fifo_count, 4);
    for (int j = 12; j < 82; j++) @(negedge clk);
    chk("fifo_count3", fifo_count, 3);
    check_frame(mk8n1(vals[1][7:0]), 10, 8, "fifoB");
    chk("fifo_count2", fifo_count, 2);
    check_frame(mk8n1(vals[2][7:0]), 10, 8, "fifoC");
    chk("fifo_count1", fifo_count, 1);
    check_frame(mk8n1(vals[3][7:0]), 10, 8, "fifoD");
    chk("fifo_count0", fifo_count, 0);
    check_frame(mk8n1(vals[4][7:0]), 10, 8, "fifoE");
    chk("fifo_idle_txd", txd, 1);
    chk("fifo_idle_busy", busy, 0);

    // Mid-frame cfg change: current frame 8N1/p1, next frame 8E1/p2
    @(negedge clk);
    push_one(9'h05A);
    @(negedge clk);
    @(negedge clk);
    chk("cfgchg_start", txd, 0);
    cfg_parity = 3'd1; prescale = 16'd2;
    axis.tdata = 9'h033; axis.tvalid = 1'b1;
    fork
      check_frame(mk8n1(8'h5A), 10, 8, "cfgA");
      begin
        @(posedge clk); #1;
        axis.tvalid = 1'b0;
      end
    join
    check_frame(16'h0466, 11, 16, "cfgB");
    chk("cfg_idle_busy", busy, 0);

    // Reset in the middle of a data bit with a queued word
    @(negedge clk);
    cfg_parity = 3'd0; prescale = 16'd1;
    push_one(9'h000);
    @(negedge clk);
    push_one(9'h000);
    repeat (12) @(negedge clk);
    chk("rstmid_pre_txd", txd, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_txd", txd, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lowcnt = 0; busycnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lowcnt++;
      if (busy !== 1'b0) busycnt++;
    end
    chk("rstmid_no_frame_txd", lowcnt, 0);
    chk("rstmid_no_frame_busy", busycnt, 0);
    chk("rstmid_count_after", fifo_count, 0);
    chk("rstmid_tready_after", axis.tready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
